mfrc522_spi_master: RTL

- SPI Mode 0 master that runs single-register read and write transactions to an MFRC522-compatible RFID front end.
- Sits between the SoC register/AXI glue (command and response side) and the external SPI pins.
- Each command is one 16-bit frame under one CS assertion: an address byte followed by a data byte.
- Paired in the integration bench with the MFRC522 SPI slave model.

---
 rtl/mfrc522_spi_master_if.sv | 22 ++
 rtl/mfrc522_spi_master.sv | 120 ++++++++++++
 2 files changed

// File: rtl/mfrc522_spi_master_if.sv
// Command/response handshake between the SoC glue and the MFRC522 SPI master.
// master = SoC side issuing commands, slave = the SPI engine serving them.
interface mfrc522_spi_master_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_rw;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       busy;

   modport master (
      output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_rdata, busy
   );

   modport slave (
      input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_rdata, busy
   );
endinterface

// File: rtl/mfrc522_spi_master.sv
// SPI mode 0 master issuing one 16-bit {rw,addr,data} frame per command to an MFRC522.
// All outputs are registered; one down-counter times every phase.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// SETUP | cs_n low, first bit on mosi, waiting one half-period before first rise
// SHIFT | 16 sck pulses; mosi moves on falls, miso sampled on rises 9-16
// HOLD  | one half-period after last fall before cs_n is released
// GAP   | cs_n high for CS_GAP cycles before the next command may be taken
module mfrc522_spi_master #(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   mfrc522_spi_master_if.slave        bus,
   output logic                       cs_n,
   output logic                       sck,
   output logic                       mosi,
   input  logic                       miso
);
   localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(CS_GAP - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       bit_cnt;
   logic [15:0]      tx_sr;
   logic [7:0]       rx_sr;
   logic             rw_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_cnt       <= '0;
         tx_sr         <= '0;
         rx_sr         <= '0;
         rw_q          <= 1'b0;
         cs_n          <= 1'b1;
         sck           <= 1'b0;
         mosi          <= 1'b0;
         bus.cmd_ready <= 1'b1;
         bus.busy      <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= 8'h00;
      end else begin
         bus.rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cmd_valid && bus.cmd_ready) begin
                  rw_q          <= bus.cmd_rw;
                  mosi          <= bus.cmd_rw;
                  tx_sr         <= {bus.cmd_addr, (bus.cmd_rw ? 8'h00 : bus.cmd_wdata), 1'b0};
                  bit_cnt       <= '0;
                  cnt           <= HALF_LOAD;
                  cs_n          <= 1'b0;
                  bus.cmd_ready <= 1'b0;
                  bus.busy      <= 1'b1;
                  state         <= SETUP;
               end
            end
            SETUP: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_ONE;
               end else begin
                  // first rise: its miso sample belongs to the address byte and is dropped
                  sck   <= 1'b1;
                  cnt   <= HALF_LOAD;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_ONE;
               end else begin
                  cnt <= HALF_LOAD;
                  if (!sck) begin
                     sck <= 1'b1;
                     if (bit_cnt[3]) rx_sr <= {rx_sr[6:0], miso};
                  end else begin
                     // zeros shifted into tx_sr leave mosi low after the 16th fall
                     sck     <= 1'b0;
                     mosi    <= tx_sr[15];
                     tx_sr   <= {tx_sr[14:0], 1'b0};
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd15) state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_ONE;
               end else begin
                  cs_n          <= 1'b1;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_rdata <= rw_q ? rx_sr : 8'h00;
                  cnt           <= GAP_LOAD;
                  state         <= GAP;
               end
            end
            GAP: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_ONE;
               end else begin
                  bus.cmd_ready <= 1'b1;
                  bus.busy      <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
